register_file: RTL and testbench

- RV32I integer register file: 32 x 32-bit general-purpose registers, x0 hardwired to zero.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Writes commit on the falling clock edge. A value written in the first half of a cycle is readable in the second half of the same cycle, so the pipeline's write-back and decode stages need no bypass logic.
- Sits between decode (rs1/rs2 addresses) and write-back (rd, data, enable).

---
 rtl/register_file.sv | 39 +++
 tb/tb_register_file.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit, x0 reads as constant zero.
// Two combinational read ports; one write port that commits on the falling clock edge.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write_en,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    // x0 has no storage; the array starts at x1.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS-1:1];

    // Falling-edge commit lets decode read the new value in the second half of the
    // cycle, so the write-back path needs no separate bypass mux.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (reg_write_en && (rd_addr != '0)) begin
            regs[rd_addr] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (rs1_addr != '0) read_data1 = regs[rs1_addr];
        if (rs2_addr != '0) read_data2 = regs[rs2_addr];
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: table of write/read vectors plus hand-written
// sequences for half-cycle write visibility and asynchronous reset.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] write_data;
    logic        reg_write_en;
    logic [31:0] read_data1, read_data2;

    int unsigned n_applied = 0;
    int unsigned n_miscompare = 0;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        we;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [10];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .write_data  (write_data),
        .reg_write_en(reg_write_en),
        .read_data1  (read_data1),
        .read_data2  (read_data2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic sweep_zero(input string name);
        logic [4:0] a;
        for (int unsigned i = 0; i < 32; i++) begin
            a = 5'(i);
            rs1_addr = a;
            rs2_addr = 5'(31 - i);
            #1;
            check({name, "_p1"}, read_data1, 32'h0);
            check({name, "_p2"}, read_data2, 32'h0);
        end
    endtask

    initial begin
        vecs[0] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd0,  wd: 32'h0,         we: 1'b0, e1: 32'h0,         e2: 32'h0};
        vecs[1] = '{rs1: 5'd1,  rs2: 5'd0,  rd: 5'd1,  wd: 32'hDEADBEEF,  we: 1'b1, e1: 32'hDEADBEEF,  e2: 32'h0};
        vecs[2] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd2,  wd: 32'hCAFEBABE,  we: 1'b1, e1: 32'hDEADBEEF,  e2: 32'hCAFEBABE};
        vecs[3] = '{rs1: 5'd2,  rs2: 5'd2,  rd: 5'd2,  wd: 32'h0,         we: 1'b0, e1: 32'hCAFEBABE,  e2: 32'hCAFEBABE};
        vecs[4] = '{rs1: 5'd0,  rs2: 5'd1,  rd: 5'd0,  wd: 32'hFFFFFFFF,  we: 1'b1, e1: 32'h0,         e2: 32'hDEADBEEF};
        vecs[5] = '{rs1: 5'd2,  rs2: 5'd0,  rd: 5'd0,  wd: 32'hFFFFFFFF,  we: 1'b0, e1: 32'hCAFEBABE,  e2: 32'h0};
        vecs[6] = '{rs1: 5'd3,  rs2: 5'd3,  rd: 5'd3,  wd: 32'h12345678,  we: 1'b0, e1: 32'h0,         e2: 32'h0};
        vecs[7] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd31, wd: 32'hA5A5A5A5,  we: 1'b1, e1: 32'hA5A5A5A5,  e2: 32'h0};
        vecs[8] = '{rs1: 5'd1,  rs2: 5'd2,  rd: 5'd1,  wd: 32'h11111111,  we: 1'b1, e1: 32'h11111111,  e2: 32'hCAFEBABE};
        vecs[9] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd30, wd: 32'h00000001,  we: 1'b1, e1: 32'hA5A5A5A5,  e2: 32'h00000001};

        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        write_data = '0; reg_write_en = 1'b0;

        // Reset held across clock edges, with a write presented that must be ignored.
        rd_addr = 5'd4; write_data = 32'h0BADF00D; reg_write_en = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        sweep_zero("reset_held");
        @(posedge clk); #1;
        reg_write_en = 1'b0;
        rst_n = 1'b1;
        #1;
        sweep_zero("after_release");

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            rs1_addr = vecs[k].rs1; rs2_addr = vecs[k].rs2;
            rd_addr = vecs[k].rd; write_data = vecs[k].wd; reg_write_en = vecs[k].we;
            @(negedge clk); #1;
            check($sformatf("vec%0d_p1", k), read_data1, vecs[k].e1);
            check($sformatf("vec%0d_p2", k), read_data2, vecs[k].e2);
        end

        // Half-cycle timing: old value before the falling edge, new value after it.
        @(posedge clk); #1;
        rd_addr = 5'd3; write_data = 32'h12345678; reg_write_en = 1'b1;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        check("rdw_before_negedge", read_data1, 32'h0);
        @(negedge clk); #1;
        check("rdw_after_negedge_p1", read_data1, 32'h12345678);
        check("rdw_after_negedge_p2", read_data2, 32'h12345678);

        // Populate x1..x31 with i replicated in each byte.
        for (int unsigned i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            rd_addr = 5'(i); write_data = {4{8'(i)}}; reg_write_en = 1'b1;
        end
        @(posedge clk); #1;
        reg_write_en = 1'b0;
        rs1_addr = 5'd17; rs2_addr = 5'd31;
        #1;
        check("populated_x17", read_data1, 32'h11111111);
        check("populated_x31", read_data2, 32'h1F1F1F1F);
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        check("populated_x5", read_data1, 32'h05050505);
        check("populated_x0", read_data2, 32'h0);

        // Asynchronous reset mid-cycle, with a pending write that must be discarded.
        rd_addr = 5'd5; write_data = 32'hABCD1234; reg_write_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        sweep_zero("async_reset");
        rd_addr = 5'd5; write_data = 32'hABCD1234; reg_write_en = 1'b1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        reg_write_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        rs1_addr = 5'd5; rs2_addr = 5'd7;
        #1;
        check("post_reset_x5", read_data1, 32'h0);
        check("post_reset_x7", read_data2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
